mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: MAXDATA, 4, max consecutive data grants while a fetch waits (1..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port: IReq  in  1  fetch-stage read request, held until IReady.
REQ-005 SHALL have port: IAddr  in  32  fetch address.
REQ-006 SHALL have port: IRData  out  32  fetched instruction word.
REQ-007 SHALL have port: IReady  out  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port: DReq  in  1  memory-stage request, held until DReady.
REQ-009 SHALL have port: DWe  in  1  1 = store, 0 = load.
REQ-010 SHALL have port: DAddr  in  32  data address.
REQ-011 SHALL have port: DWData  in  32  store data.
REQ-012 SHALL have port: DRData  out  32  load data.
REQ-013 SHALL have port: DReady  out  1  one-cycle data completion pulse.
REQ-014 SHALL have port: StallF  out  1  IReq & ~IReady, combinational.
REQ-015 SHALL have port: StallM  out  1  DReq & ~DReady, combinational.
REQ-016 SHALL have port: MemReq  out  1  unified memory request.
REQ-017 SHALL have port: MemWe  out  1  unified memory write enable.
REQ-018 SHALL have port: MemAddr  out  32  unified memory address.
REQ-019 SHALL have port: MemWData  out  32  unified memory write data.
REQ-020 SHALL have port: MemRData  in  32  unified memory read data, valid with MemAck.
REQ-021 SHALL have port: MemAck  in  1  memory completion, any latency >= 0 cycles after MemReq rises.

Function
REQ-022 SHALL implement FSM states IDLE, IBUSY, DBUSY, RESP.
REQ-023 IDLE: DReq & (~IReq | streak<MAXDATA) -> DBUSY; else IReq -> IBUSY; else stay IDLE.
REQ-024 On leaving IDLE SHALL latch address, write enable and write data of the granted port into registers driving MemAddr/MemWe/MemWData; MemWe=0 for fetch.
REQ-025 MemReq SHALL be 1 exactly in IBUSY/DBUSY, with MemAddr/MemWe/MemWData stable until MemAck.
REQ-026 IBUSY/DBUSY with MemAck -> RESP, capturing MemRData into IRData (IBUSY) or DRData (DBUSY load); store leaves DRData unchanged.
REQ-027 RESP SHALL assert IReady or DReady (per granted port) for exactly one cycle, then -> IDLE.
REQ-028 Minimum latency: request sampled in IDLE at cycle t, MemAck at t+1, Ready at t+2, next grant decision at t+3.
REQ-029 Req held during its Ready cycle SHALL be ignored; a request seen in IDLE afterwards is a new transaction.
REQ-030 streak SHALL increment (saturating at MAXDATA) on each data grant made while IReq=1, and clear on a fetch grant or any IDLE decision with IReq=0.
REQ-031 MemAck in IDLE or RESP SHALL be ignored.
REQ-032 IReady and DReady SHALL never both be 1; at most one memory transaction outstanding.
REQ-033 Requester input changes during BUSY SHALL not affect Mem* outputs.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, MemReq=0, MemWe=0, IReady=0, DReady=0, streak=0, MemAddr/MemWData/IRData/DRData=0, including mid-transaction.
REQ-035 An aborted transaction SHALL not be replayed after reset release; requesters re-request.

Structure
REQ-036 State enum and MAXDATA default SHALL live in shared package arm_mem_pkg.
REQ-037 The streak counter SHALL be sub-module starve_ctr (inc, clr, sat output); the rest stays flat.

Verification
REQ-038 IReq=1, IAddr=0x10, MemAck one cycle after MemReq, MemRData=0xE3A00005 -> IReady pulse 2 cycles after request, IRData=0xE3A00005.
REQ-039 IReq and DReq (load 0x80) both from cycle 0 -> data granted first, DReady then IReady, StallF high throughout.
REQ-040 DReq held continuously with IReq=1, MAXDATA=4 -> exactly 4 data grants, then 1 fetch grant, pattern repeats.
REQ-041 Store DAddr=0x40, DWData=0xDEADBEEF, MemAck delayed 5 cycles -> MemWe=1, MemAddr/MemWData stable 5 cycles, DRData unchanged.
REQ-042 reset=0 in DBUSY before MemAck -> MemReq low same cycle, no Ready pulse; after release new IReq served normally.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  - arbiter FSM state encoding
//   MAXDATA_DEF  - default bound on back-to-back data grants while a fetch waits
//   STREAK_W     - width of the starvation counter (holds 0..15)
//   is_busy()    - true while a memory transaction is outstanding
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int unsigned MAXDATA_DEF = 4;
  localparam int unsigned STREAK_W    = 4;

  function automatic logic is_busy(input arb_state_t s);
    return (s == IBUSY) || (s == DBUSY);
  endfunction

endpackage

// File: rtl/starve_ctr.sv
// Counts consecutive data grants made while a fetch is pending; flags saturation.
// Latency: count updates one cycle after inc/clr; sat is a decode of the register.
// Backpressure: none; inc is ignored once saturated, clr has priority over inc.
//
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   inc        - a data grant was made while the fetch port was requesting
//   clr        - a fetch grant, or an arbitration decision with no fetch pending
//   sat        - counter has reached MAX; the fetch port must win next
module starve_ctr
  import arm_mem_pkg::*;
#(
  parameter int unsigned MAX = MAXDATA_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX);

  logic [STREAK_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one unified memory port.
// Latency: grant in IDLE at t, MemAck earliest t+1, Ready at t+2, next decision t+3.
// Backpressure: requesters hold Req until Ready; memory stalls by delaying MemAck.
//
// Ports:
//   clk, reset                          - clock, asynchronous active-low reset
//   IReq/IAddr -> IRData/IReady/StallF  - fetch requester
//   DReq/DWe/DAddr/DWData -> DRData/DReady/StallM - data requester
//   MemReq/MemWe/MemAddr/MemWData       - unified memory request (held until MemAck)
//   MemRData/MemAck                     - unified memory response
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned MAXDATA = MAXDATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRData,
  output logic        IReady,
  // data port
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic [31:0] DRData,
  output logic        DReady,
  // pipeline stalls
  output logic        StallF,
  output logic        StallM,
  // unified memory
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  arb_state_t state, state_nxt;

  logic        ld_i;       // fetch granted this cycle
  logic        ld_d;       // data granted this cycle
  logic        str_inc;
  logic        str_clr;
  logic        str_sat;
  logic        mem_done;   // MemAck seen while a transaction is outstanding

  logic        sel_d_q;    // port owning the current/last transaction: 1 = data
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Data normally wins; once it has won MAXDATA times in a row against a
  // waiting fetch, the fetch gets the next slot. Requests are only sampled in
  // IDLE, so a Req still held during its own Ready cycle is not re-served
  // until the FSM is back in IDLE, where it counts as a fresh transaction.
  always_comb begin
    state_nxt = state;
    ld_i      = 1'b0;
    ld_d      = 1'b0;
    str_inc   = 1'b0;
    str_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (DReq && (!IReq || !str_sat)) begin
          state_nxt = DBUSY;
          ld_d      = 1'b1;
          str_inc   = IReq;
          str_clr   = !IReq;
        end else if (IReq) begin
          state_nxt = IBUSY;
          ld_i      = 1'b1;
          str_clr   = 1'b1;
        end else begin
          str_clr   = 1'b1;
        end
      end
      IBUSY, DBUSY: begin
        if (MemAck) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // MemAck outside IBUSY/DBUSY has no effect anywhere.
  assign mem_done = is_busy(state) && MemAck;

  // ---------------------------------------------------------------------------
  // Request and response registers
  // ---------------------------------------------------------------------------
  // Loaded only on a grant, so requester inputs moving during BUSY cannot
  // disturb the memory-side signals.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_d_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (ld_d) begin
      sel_d_q <= 1'b1;
      we_q    <= DWe;
      addr_q  <= DAddr;
      wdata_q <= DWData;
    end else if (ld_i) begin
      sel_d_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= IAddr;
      wdata_q <= '0;
    end
  end

  // A store completion leaves DRData holding the last load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irdata_q <= '0;
      drdata_q <= '0;
    end else if (mem_done) begin
      if (state == IBUSY) begin
        irdata_q <= MemRData;
      end else if (!we_q) begin
        drdata_q <= MemRData;
      end
    end
  end

  starve_ctr #(
    .MAX (MAXDATA)
  ) u_starve_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (str_inc),
    .clr   (str_clr),
    .sat   (str_sat)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // MemReq is a pure state decode so an asynchronous reset drops it at once.
  assign MemReq   = is_busy(state);
  assign MemWe    = MemReq && we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;

  // Only one transaction is ever in RESP, so the two Ready pulses are exclusive.
  assign IReady   = (state == RESP) && !sel_d_q;
  assign DReady   = (state == RESP) &&  sel_d_q;
  assign IRData   = irdata_q;
  assign DRData   = drdata_q;

  assign StallF   = IReq && !IReady;
  assign StallM   = DReq && !DReady;

endmodule
